// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared FSM encodings, mode bit indices and line-ending characters
package uart_echo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_LF   = 2'd2
  } state_t;

  localparam int MODE_CRLF = 0;
  localparam int MODE_DROP = 1;

  localparam logic [7:0] CR_CHAR = 8'h0D;
  localparam logic [7:0] LF_CHAR = 8'h0A;

endpackage

// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - circular word buffer with occupancy count, combinational head read
module uart_echo_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [AW:0]           o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;

  // Storage is not reset; a cleared count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - UART RX-to-TX echo buffer with optional CR->CRLF expansion and drop-on-full
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic [1:0]            mode,
  output logic [AW:0]           count,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  // Narrow words see only the low bits of the line-ending characters.
  localparam int CW = (DATA_WIDTH < 8) ? DATA_WIDTH : 8;
  localparam logic [DATA_WIDTH-1:0] LF_WORD = DATA_WIDTH'(LF_CHAR);
  localparam logic [CW-1:0]         CR_BITS = CW'(CR_CHAR);

  state_t                r_state;
  state_t                w_next;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] w_head;
  logic [AW:0]           w_count;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_is_cr;
  logic                  w_more_data;
  logic                  w_more_lf;

  uart_echo_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (s_axis_tdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign s_axis_tready = !rst && (mode[MODE_DROP] || !w_full);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_push        = w_accept && !w_full;
  assign w_drop        = w_accept && w_full;
  assign w_pop         = (r_state == ST_DATA) && m_axis_tready;
  assign w_is_cr       = (w_head[CW-1:0] == CR_BITS);
  // A same-cycle push counts as "more" so streaming keeps one word per cycle.
  assign w_more_data   = (w_count > (AW+1)'(1)) || w_push;
  assign w_more_lf     = !w_empty || w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_next        = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_next = ST_DATA;
      end
      ST_DATA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_head;
        if (m_axis_tready) begin
          if (mode[MODE_CRLF] && w_is_cr) w_next = ST_LF;
          else if (w_more_data)           w_next = ST_DATA;
          else                            w_next = ST_IDLE;
        end
      end
      ST_LF: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = LF_WORD;
        if (m_axis_tready) w_next = w_more_lf ? ST_DATA : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign count    = w_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb/tb_uart_echo_buffer.sv - directed self-checking bench for uart_echo_buffer
module tb_uart_echo_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [1:0]    mode;
  logic [AW:0]   count;
  logic          overflow;
  logic          overflow_clr;

  int tests = 0;
  int fails = 0;

  logic [7:0] v39 [4] = '{8'h0D, 8'h61, 8'h62, 8'h63};

  uart_echo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .mode          (mode),
    .count         (count),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    m_axis_tready = 1'b0; mode = 2'b00; overflow_clr = 1'b0;
    step(); step();
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
    chk("rst_count",  32'(count),         32'd0);
    chk("rst_ovf",    32'(overflow),      32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_tready", 32'(s_axis_tready), 32'd1);

    // Plain echo, first word one cycle after acceptance
    mode = 2'b00; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h41; step();
    chk("e_cnt1", 32'(count), 32'd1);
    chk("e_idle", 32'(m_axis_tvalid), 32'd0);
    s_axis_tdata = 8'h42; step();
    chk("e_v0",   32'(m_axis_tvalid), 32'd1);
    chk("e_d0",   32'(m_axis_tdata),  32'h41);
    chk("e_cnt2", 32'(count), 32'd2);
    s_axis_tvalid = 1'b0; step();
    chk("e_d1",   32'(m_axis_tdata),  32'h42);
    chk("e_cnt3", 32'(count), 32'd1);
    step();
    chk("e_done_v", 32'(m_axis_tvalid), 32'd0);
    chk("e_done_c", 32'(count), 32'd0);

    // CR expansion
    mode = 2'b01;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h0D; step();
    chk("c_cnt1", 32'(count), 32'd1);
    s_axis_tdata = 8'h31; step();
    s_axis_tvalid = 1'b0;
    chk("c_d0",   32'(m_axis_tdata), 32'h0D);
    chk("c_cnt2", 32'(count), 32'd2);
    step();
    chk("c_lf",   32'(m_axis_tdata), 32'h0A);
    chk("c_lf_v", 32'(m_axis_tvalid), 32'd1);
    chk("c_cnt3", 32'(count), 32'd1);
    step();
    chk("c_d2",   32'(m_axis_tdata), 32'h31);
    step();
    chk("c_done_v", 32'(m_axis_tvalid), 32'd0);
    chk("c_done_c", 32'(count), 32'd0);

    // Backpressure on full
    mode = 2'b00; m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h10 + i); step();
    end
    s_axis_tdata = 8'h20;
    chk("bp_cnt16", 32'(count), 32'd16);
    chk("bp_trdy0", 32'(s_axis_tready), 32'd0);
    step();
    chk("bp_hold_cnt", 32'(count), 32'd16);
    chk("bp_ovf0",     32'(overflow), 32'd0);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k == 2) s_axis_tvalid = 1'b0;
      chk("bp_drain_v", 32'(m_axis_tvalid), 32'd1);
      chk("bp_drain_d", 32'(m_axis_tdata), 32'(8'h10 + k));
      step();
    end
    chk("bp_end_v", 32'(m_axis_tvalid), 32'd0);
    chk("bp_end_c", 32'(count), 32'd0);

    // Drop on full, sticky overflow and clear
    mode = 2'b10; m_axis_tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 16) chk("dr_ovf_pre", 32'(overflow), 32'd0);
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h30 + i); step();
    end
    s_axis_tvalid = 1'b0;
    chk("dr_cnt16", 32'(count), 32'd16);
    chk("dr_ovf1",  32'(overflow), 32'd1);
    chk("dr_trdy",  32'(s_axis_tready), 32'd1);
    chk("dr_head",  32'(m_axis_tdata), 32'h30);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("dr_clr", 32'(overflow), 32'd0);
    overflow_clr = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 8'h77; step();
    overflow_clr = 1'b0; s_axis_tvalid = 1'b0;
    chk("dr_setwins", 32'(overflow), 32'd1);
    chk("dr_setwins_c", 32'(count), 32'd16);
    step();
    chk("dr_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;
    chk("dr_clr2", 32'(overflow), 32'd0);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h78; m_axis_tready = 1'b1; step();
    s_axis_tvalid = 1'b0;
    chk("dr_poppush_ovf", 32'(overflow), 32'd1);
    chk("dr_poppush_c",   32'(count), 32'd15);
    for (int k = 1; k < 16; k++) begin
      chk("dr_drain_d", 32'(m_axis_tdata), 32'(8'h30 + k));
      step();
    end
    chk("dr_end_v", 32'(m_axis_tvalid), 32'd0);
    chk("dr_end_c", 32'(count), 32'd0);
    overflow_clr = 1'b1; step(); overflow_clr = 1'b0;

    // Full-rate streaming across three pointer wraps
    mode = 2'b00; m_axis_tready = 1'b1;
    for (int j = 0; j < 50; j++) begin
      if (j == 1) chk("st_cnt1", 32'(count), 32'd1);
      if (j >= 2) chk("st_d", 32'(m_axis_tdata), 32'(8'h80 + j - 2));
      if (j >= 2 && j <= 48) chk("st_cnt", 32'(count), 32'd2);
      if (j < 48) begin
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h80 + j);
      end else begin
        s_axis_tvalid = 1'b0;
      end
      step();
    end
    chk("st_end_v", 32'(m_axis_tvalid), 32'd0);
    chk("st_end_c", 32'(count), 32'd0);

    // Reset while LF pending
    mode = 2'b01; m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = v39[i]; step();
    end
    s_axis_tvalid = 1'b0;
    chk("rl_cnt4", 32'(count), 32'd4);
    chk("rl_head", 32'(m_axis_tdata), 32'h0D);
    m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;
    chk("rl_lf",   32'(m_axis_tdata), 32'h0A);
    chk("rl_cnt3", 32'(count), 32'd3);
    rst = 1'b1; step();
    chk("rl_rst_v",    32'(m_axis_tvalid), 32'd0);
    chk("rl_rst_c",    32'(count), 32'd0);
    chk("rl_rst_trdy", 32'(s_axis_tready), 32'd0);
    chk("rl_rst_d",    32'(m_axis_tdata), 32'd0);
    rst = 1'b0; mode = 2'b00; m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h55; step();
    s_axis_tvalid = 1'b0;
    chk("rl_new_c", 32'(count), 32'd1);
    step();
    chk("rl_new_v", 32'(m_axis_tvalid), 32'd1);
    chk("rl_new_d", 32'(m_axis_tdata), 32'h55);
    step();
    chk("rl_end_v", 32'(m_axis_tvalid), 32'd0);
    chk("rl_end_c", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
